// File: rtl/adaptive_step_controller.sv
// Adaptive step-size controller: reads CHANNELS low/high estimate pairs, forms the
// max-norm error, accepts/rejects the step and computes SAFETY*h*tol/err, clamped.
module adaptive_step_controller #(
  parameter int WORD_SIZE     = 16,
  parameter int FRAC_BITS     = 7,
  parameter int ADDRESS_WIDTH = 4,
  parameter int CHANNELS      = 4,
  parameter int SAFETY        = 115,
  parameter int MAX_RETRIES   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  input  logic                     start,
  input  logic                     load_step,
  input  logic [WORD_SIZE-1:0]     step_in,
  input  logic [WORD_SIZE-1:0]     step_min,
  input  logic [WORD_SIZE-1:0]     step_max,
  input  logic [WORD_SIZE-1:0]     tolerance,
  input  logic [ADDRESS_WIDTH-1:0] x0_base,
  input  logic [ADDRESS_WIDTH-1:0] x1_base,
  input  logic [WORD_SIZE-1:0]     mem_data1,
  input  logic [WORD_SIZE-1:0]     mem_data2,
  output logic                     mem_read,
  output logic [ADDRESS_WIDTH-1:0] mem_address1,
  output logic [ADDRESS_WIDTH-1:0] mem_address2,
  output logic                     done,
  output logic                     accept,
  output logic                     reject,
  output logic                     error_failure,
  output logic                     busy,
  output logic [WORD_SIZE-1:0]     step_out,
  output logic [WORD_SIZE-1:0]     error_norm
);

  localparam int WS    = WORD_SIZE;
  localparam int AW    = ADDRESS_WIDTH;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int RT_W  = $clog2(MAX_RETRIES + 1);
  localparam int CNT_W = $clog2(WORD_SIZE);
  localparam int PW    = 3 * WORD_SIZE;
  localparam int DW    = 2 * WORD_SIZE;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_ACC, S_SCALE, S_DIV, S_CLAMP, S_DONE
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   ch;
  logic [AW-1:0]     x0_b, x1_b;
  logic [WS-1:0]     smin, smax, tol_r;
  logic [WS-1:0]     err;
  logic [WS-1:0]     rem, dlo, quo;
  logic              ovf;
  logic [CNT_W-1:0]  cnt;
  logic [RT_W-1:0]   retry;

  logic [WS:0]       diff, mag, trial;
  logic [WS-1:0]     abs_sat, err_nx;
  logic [PW-1:0]     prod1, prod2;
  logic [WS-1:0]     p_sat;
  logic [DW-1:0]     dvd;
  logic [WS-1:0]     q_fin, q_lo, new_step;
  logic [RT_W-1:0]   retry_nx;
  logic [CH_W-1:0]   ch_inc;

  always_comb begin
    diff     = {mem_data2[WS-1], mem_data2} - {mem_data1[WS-1], mem_data1};
    mag      = diff[WS] ? ((WS+1)'(0) - diff) : diff;
    abs_sat  = (mag > {2'b00, {(WS-1){1'b1}}}) ? {1'b0, {(WS-1){1'b1}}} : mag[WS-1:0];
    err_nx   = (abs_sat > err) ? abs_sat : err;
    ch_inc   = ch + CH_W'(1);
    prod1    = (PW'(step_out) * PW'(tol_r)) >> FRAC_BITS;
    prod2    = (prod1 * PW'(SAFETY)) >> FRAC_BITS;
    p_sat    = (prod2 > PW'({WS{1'b1}})) ? '1 : prod2[WS-1:0];
    dvd      = DW'(p_sat) << FRAC_BITS;
    trial    = {rem, dlo[WS-1]};
    q_fin    = ovf ? '1 : quo;
    q_lo     = (q_fin < smin) ? smin : q_fin;
    new_step = (q_lo > smax) ? smax : q_lo;
    retry_nx = (retry == RT_W'(MAX_RETRIES)) ? retry : retry + RT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      ch            <= '0;
      x0_b          <= '0;
      x1_b          <= '0;
      smin          <= '0;
      smax          <= '0;
      tol_r         <= '0;
      err           <= '0;
      rem           <= '0;
      dlo           <= '0;
      quo           <= '0;
      ovf           <= 1'b0;
      cnt           <= '0;
      retry         <= '0;
      mem_read      <= 1'b0;
      mem_address1  <= '0;
      mem_address2  <= '0;
      done          <= 1'b0;
      accept        <= 1'b0;
      reject        <= 1'b0;
      error_failure <= 1'b0;
      busy          <= 1'b0;
      step_out      <= '0;
      error_norm    <= '0;
    end else begin
      done         <= 1'b0;
      accept       <= 1'b0;
      reject       <= 1'b0;
      mem_read     <= 1'b0;
      mem_address1 <= '0;
      mem_address2 <= '0;
      case (state)
        S_IDLE: begin
          if (init) begin
            retry         <= '0;
            error_failure <= 1'b0;
          end
          if (load_step) step_out <= step_in;
          if (start) begin
            x0_b         <= x0_base;
            x1_b         <= x1_base;
            smin         <= step_min;
            smax         <= step_max;
            tol_r        <= tolerance;
            ch           <= '0;
            err          <= '0;
            mem_read     <= 1'b1;
            mem_address1 <= x0_base;
            mem_address2 <= x1_base;
            busy         <= 1'b1;
            state        <= S_READ;
          end
        end
        S_READ: state <= S_ACC;
        S_ACC: begin
          err <= err_nx;
          if (ch == CH_W'(CHANNELS - 1)) begin
            state <= S_SCALE;
          end else begin
            ch           <= ch_inc;
            mem_read     <= 1'b1;
            mem_address1 <= x0_b + AW'(ch_inc);
            mem_address2 <= x1_b + AW'(ch_inc);
            state        <= S_READ;
          end
        end
        S_SCALE: begin
          // Remainder starts with the dividend's upper half; a no-overflow quotient
          // then fits in WS bits and the low half is shifted in one bit per cycle.
          rem <= dvd[DW-1:WS];
          dlo <= dvd[WS-1:0];
          quo <= '0;
          cnt <= '0;
          if (err == '0) begin
            ovf   <= 1'b1;
            state <= S_CLAMP;
          end else begin
            ovf   <= (dvd[DW-1:WS] >= err);
            state <= S_DIV;
          end
        end
        S_DIV: begin
          if (trial >= {1'b0, err}) begin
            rem <= WS'(trial - {1'b0, err});
            quo <= {quo[WS-2:0], 1'b1};
          end else begin
            rem <= trial[WS-1:0];
            quo <= {quo[WS-2:0], 1'b0};
          end
          dlo <= {dlo[WS-2:0], 1'b0};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WORD_SIZE - 1)) state <= S_CLAMP;
        end
        S_CLAMP: begin
          done       <= 1'b1;
          step_out   <= new_step;
          error_norm <= err;
          if (err <= tol_r) begin
            accept <= 1'b1;
            retry  <= '0;
          end else begin
            reject <= 1'b1;
            retry  <= retry_nx;
            if (retry_nx == RT_W'(MAX_RETRIES) || q_fin < smin) error_failure <= 1'b1;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adaptive_step_controller.sv
// Bench for adaptive_step_controller: fixed vectors, hand sequences and random
// evaluations checked against an arithmetic reference model.
module tb_adaptive_step_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init = 1'b0, start = 1'b0, load_step = 1'b0;
  logic [15:0] step_in = '0, step_min = '0, step_max = '0, tolerance = '0;
  logic [3:0]  x0_base = '0, x1_base = '0;
  logic [15:0] mem_data1 = '0, mem_data2 = '0;
  logic        mem_read, done, accept, reject, error_failure, busy;
  logic [3:0]  mem_address1, mem_address2;
  logic [15:0] step_out, error_norm;

  adaptive_step_controller #(
    .WORD_SIZE(16), .FRAC_BITS(7), .ADDRESS_WIDTH(4),
    .CHANNELS(4), .SAFETY(115), .MAX_RETRIES(8)
  ) dut (
    .clk(clk), .rst(rst), .init(init), .start(start), .load_step(load_step),
    .step_in(step_in), .step_min(step_min), .step_max(step_max), .tolerance(tolerance),
    .x0_base(x0_base), .x1_base(x1_base), .mem_data1(mem_data1), .mem_data2(mem_data2),
    .mem_read(mem_read), .mem_address1(mem_address1), .mem_address2(mem_address2),
    .done(done), .accept(accept), .reject(reject), .error_failure(error_failure),
    .busy(busy), .step_out(step_out), .error_norm(error_norm)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [16];
  always @(posedge clk) begin
    if (mem_read) begin
      mem_data1 <= mem[mem_address1];
      mem_data2 <= mem[mem_address2];
    end
  end

  int total = 0;
  int bad = 0;
  longint m_step = 0;
  int m_retry = 0;
  int m_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the memory contents.
  task automatic model_eval(output int lat, output int acc, output int errn,
                            output int stp, output int fl);
    longint e, a0, a1, d, p, q, n;
    e = 0;
    for (int c = 0; c < 4; c++) begin
      a0 = $signed(mem[4'(x0_base + c)]);
      a1 = $signed(mem[4'(x1_base + c)]);
      d = a1 - a0;
      if (d < 0) d = -d;
      if (d > 32767) d = 32767;
      if (d > e) e = d;
    end
    p = (((m_step * longint'(tolerance)) / 128) * 115) / 128;
    if (p > 65535) p = 65535;
    q = (e == 0) ? 65535 : (p * 128) / e;
    if (q > 65535) q = 65535;
    n = (q < step_min) ? longint'(step_min) : q;
    if (n > step_max) n = step_max;
    acc = (e <= tolerance) ? 1 : 0;
    if (acc == 1) m_retry = 0;
    else begin
      if (m_retry < 8) m_retry++;
      if (m_retry >= 8 || q < step_min) m_fail = 1;
    end
    m_step = n;
    lat  = (e == 0) ? 10 : 26;
    errn = int'(e);
    stp  = int'(n);
    fl   = m_fail;
  endtask

  task automatic idle_ctrl(input bit i, input bit l, input int v);
    @(negedge clk);
    init = i; load_step = l; step_in = 16'(v);
    @(negedge clk);
    init = 1'b0; load_step = 1'b0;
    if (i) begin m_retry = 0; m_fail = 0; end
    if (l) m_step = 16'(v);
  endtask

  task automatic drive_eval(input bit il, input int il_step, input bit poke,
                            output int lat, output int acc, output int rej,
                            output int errn, output int stp, output int fl);
    lat = -1; acc = 0; rej = 0; errn = 0; stp = 0; fl = 0;
    @(negedge clk);
    start = 1'b1;
    if (il) begin init = 1'b1; load_step = 1'b1; step_in = 16'(il_step); end
    @(negedge clk);
    start = 1'b0; init = 1'b0; load_step = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk("busy_after_start", busy, 1);
      if (poke && k == 5) start = 1'b1;
      if (poke && k == 6) start = 1'b0;
      if (done) begin
        lat = k; acc = accept; rej = reject; errn = error_norm;
        stp = step_out; fl = error_failure;
        break;
      end
    end
    start = 1'b0;
    if (lat < 0) chk("done_timeout", done, 1);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1 chk("start_ignored_busy", busy, 0);
    end
  endtask

  task automatic check_res(input string tag, input int lat, input int acc, input int rej,
                           input int errn, input int stp, input int fl,
                           input int elat, input int eacc, input int eerr,
                           input int estp, input int efl);
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_accept"}, acc, eacc);
    chk({tag, "_reject"}, rej, 1 - eacc);
    chk({tag, "_error_norm"}, errn, eerr);
    chk({tag, "_step_out"}, stp, estp);
    chk({tag, "_error_failure"}, fl, efl);
  endtask

  task automatic set_common(input logic [3:0][15:0] x0, input logic [3:0][15:0] x1);
    tolerance = 16; step_min = 8; step_max = 512;
    x0_base = 4'd0; x1_base = 4'd8;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int c = 0; c < 4; c++) begin
      mem[4'(c)]     = x0[c];
      mem[4'(8 + c)] = x1[c];
    end
  endtask

  typedef struct packed {
    logic [3:0][15:0] x0;
    logic [3:0][15:0] x1;
    int lat, acc, err, stp, fl;
  } vec_t;

  vec_t tv [4];
  logic [3:0][15:0] acc_x0, acc_x1, rj_x1;

  initial begin
    int lat, acc, rej, errn, stp, fl;
    int elat, eacc, eerr, estp, efl;
    int dn;

    tv[0] = '{x0: {16'd0, 16'd0, 16'd0, 16'd0}, x1: {16'd0, 16'd2, 16'd8, 16'd4},
              lat: 26, acc: 1, err: 8, stp: 224, fl: 0};
    tv[1] = '{x0: {16'd0, 16'd0, 16'd0, 16'd0}, x1: {16'd32, 16'd32, 16'd32, 16'd32},
              lat: 26, acc: 0, err: 32, stp: 56, fl: 0};
    tv[2] = '{x0: {16'd300, 16'hFFFB, 16'd7, 16'd100}, x1: {16'd300, 16'hFFFB, 16'd7, 16'd100},
              lat: 10, acc: 1, err: 0, stp: 512, fl: 0};
    tv[3] = '{x0: {16'd0, 16'd0, 16'd0, 16'h8000}, x1: {16'd0, 16'd0, 16'd0, 16'h7FFF},
              lat: 26, acc: 0, err: 32767, stp: 8, fl: 1};
    acc_x0 = tv[0].x0; acc_x1 = tv[0].x1; rj_x1 = tv[1].x1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step_out", step_out, 0);
    chk("rst_error_norm", error_norm, 0);
    chk("rst_error_failure", error_failure, 0);
    chk("rst_mem_read", mem_read, 0);
    @(negedge clk);
    rst = 1'b0;

    // Fixed vectors
    for (int i = 0; i < 4; i++) begin
      set_common(tv[i].x0, tv[i].x1);
      idle_ctrl(1'b1, 1'b1, 128);
      model_eval(elat, eacc, eerr, estp, efl);
      drive_eval(1'b0, 0, 1'b0, lat, acc, rej, errn, stp, fl);
      check_res($sformatf("vec%0d", i), lat, acc, rej, errn, stp, fl,
                tv[i].lat, tv[i].acc, tv[i].err, tv[i].stp, tv[i].fl);
    end

    // Retry limit: reload step each time so only the retry count can trip the flag
    set_common(acc_x0, rj_x1);
    idle_ctrl(1'b1, 1'b1, 128);
    for (int k = 1; k <= 8; k++) begin
      idle_ctrl(1'b0, 1'b1, 128);
      model_eval(elat, eacc, eerr, estp, efl);
      drive_eval(1'b0, 0, (k == 3), lat, acc, rej, errn, stp, fl);
      check_res($sformatf("retry%0d", k), lat, acc, rej, errn, stp, fl,
                elat, eacc, eerr, estp, efl);
      chk($sformatf("retry%0d_flag", k), fl, (k == 8) ? 1 : 0);
    end
    idle_ctrl(1'b1, 1'b0, 0);
    #1 chk("init_clears_failure", error_failure, 0);

    // init + load_step + start together
    set_common(acc_x0, acc_x1);
    idle_ctrl(1'b0, 1'b1, 40);
    m_retry = 0; m_fail = 0; m_step = 128;
    model_eval(elat, eacc, eerr, estp, efl);
    drive_eval(1'b1, 128, 1'b0, lat, acc, rej, errn, stp, fl);
    check_res("combo", lat, acc, rej, errn, stp, fl, elat, eacc, eerr, estp, efl);

    // Reset during the division phase
    set_common(acc_x0, rj_x1);
    idle_ctrl(1'b0, 1'b1, 128);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_step_out", step_out, 0);
    chk("midrst_error_norm", error_norm, 0);
    chk("midrst_done", done, 0);
    m_step = 0; m_retry = 0; m_fail = 0;
    @(negedge clk); rst = 1'b0;
    dn = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("midrst_no_done", dn, 0);
    set_common(acc_x0, acc_x1);
    idle_ctrl(1'b0, 1'b1, 128);
    model_eval(elat, eacc, eerr, estp, efl);
    drive_eval(1'b0, 0, 1'b0, lat, acc, rej, errn, stp, fl);
    check_res("after_rst", lat, acc, rej, errn, stp, fl, elat, eacc, eerr, estp, efl);
    chk("after_rst_step_value", stp, 224);

    // Random evaluations
    for (int it = 0; it < 40; it++) begin
      x0_base = 4'($urandom_range(0, 15));
      x1_base = 4'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      if ($urandom_range(0, 2) != 0) begin
        for (int c = 0; c < 4; c++)
          mem[4'(x1_base + c)] = mem[4'(x0_base + c)] + 16'($urandom_range(0, 60)) - 16'd30;
      end
      tolerance = 16'($urandom_range(0, 400));
      step_min  = 16'($urandom_range(0, 64));
      step_max  = 16'($urandom_range(64, 4000));
      if ($urandom_range(0, 3) == 0) idle_ctrl(1'b1, 1'b1, $urandom_range(16, 2048));
      else if ($urandom_range(0, 2) == 0) idle_ctrl(1'b0, 1'b1, $urandom_range(16, 2048));
      model_eval(elat, eacc, eerr, estp, efl);
      drive_eval(1'b0, 0, 1'b0, lat, acc, rej, errn, stp, fl);
      check_res($sformatf("rnd%0d", it), lat, acc, rej, errn, stp, fl,
                elat, eacc, eerr, estp, efl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
